rtsnoc_port_arbiter: RTL and testbench

//  Shares one RTSNoC router local port among N_CLIENTS hardware clients.
//  TX: round-robin arbitration of client flits onto noc_din_o/noc_wr_o under noc_wait_i back-pressure.
//  RX: pops each flit flagged by noc_nd_i, then steers it to one client by the client-select field.

---
 rtl/rtsnoc_pkg.sv | 34 +++
 rtl/rtsnoc_rr_arbiter.sv | 28 ++
 rtl/rtsnoc_port_arbiter.sv | 133 +++++++++++++
 tb/tb_rtsnoc_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtsnoc_pkg.sv
// Shared sizing helpers, header field offsets and FSM encodings for the RTSNoC port arbiter.
package rtsnoc_pkg;

    localparam int LOCAL_ADDR_W = 3;

    // The client-select field is as wide as the largest legal client count (8),
    // so any value >= N_CLIENTS can be recognised and dropped.
    localparam int CLIENT_FIELD_W = 3;

    localparam logic [0:0] T_IDLE  = 1'b0;
    localparam logic [0:0] T_SEND  = 1'b1;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_OFFER = 2'd1;
    localparam logic [1:0] R_GAP   = 2'd2;

    function automatic int calc_bus_w(input int data_w, input int size_x, input int size_y);
        return data_w + 2 * LOCAL_ADDR_W + 2 * size_x + 2 * size_y;
    endfunction

    function automatic int calc_cw(input int n_clients);
        return (n_clients > 1) ? $clog2(n_clients) : 1;
    endfunction

    // Header sits above the payload: local src, local dst, then src/dst X and Y.
    function automatic int hdr_local_src_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int hdr_local_dst_lsb(input int data_w);
        return data_w + LOCAL_ADDR_W;
    endfunction

endpackage

// File: rtl/rtsnoc_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, cyclically.
module rtsnoc_rr_arbiter
    import rtsnoc_pkg::*;
#(
    parameter int N_CLIENTS = 4,
    parameter int CW        = calc_cw(N_CLIENTS)
) (
    input  logic [N_CLIENTS-1:0] req,
    input  logic [CW-1:0]        ptr,
    output logic [N_CLIENTS-1:0] grant,
    output logic [CW-1:0]        grant_idx,
    output logic                 grant_valid
);

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (!grant_valid && req[CW'((int'(ptr) + i) % N_CLIENTS)]) begin
                grant_valid = 1'b1;
                grant_idx   = CW'((int'(ptr) + i) % N_CLIENTS);
                grant[CW'((int'(ptr) + i) % N_CLIENTS)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rtsnoc_port_arbiter.sv
// Shares one RTSNoC router local port among several clients: round-robin TX, client-steered RX.
module rtsnoc_port_arbiter
    import rtsnoc_pkg::*;
#(
    parameter int N_CLIENTS      = 4,
    parameter int NOC_DATA_WIDTH = 56,
    parameter int SOC_SIZE_X     = 1,
    parameter int SOC_SIZE_Y     = 1,
    localparam int BUS_W         = calc_bus_w(NOC_DATA_WIDTH, SOC_SIZE_X, SOC_SIZE_Y),
    localparam int CW            = calc_cw(N_CLIENTS)
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic [N_CLIENTS-1:0]         tx_req_i,
    input  logic [N_CLIENTS*BUS_W-1:0]   tx_flit_i,
    output logic [N_CLIENTS-1:0]         tx_ack_o,
    output logic [N_CLIENTS-1:0]         rx_valid_o,
    input  logic [N_CLIENTS-1:0]         rx_ready_i,
    output logic [BUS_W-1:0]             rx_flit_o,
    output logic [7:0]                   rx_drop_cnt_o,
    output logic [BUS_W-1:0]             noc_din_o,
    output logic                         noc_wr_o,
    input  logic                         noc_wait_i,
    input  logic [BUS_W-1:0]             noc_dout_i,
    input  logic                         noc_nd_i,
    output logic                         noc_rd_o
);

    localparam logic [N_CLIENTS-1:0] ONE_HOT_0 = N_CLIENTS'(1);

    logic [0:0]              tx_state;
    logic [CW-1:0]           rr_ptr;
    logic [CW-1:0]           tx_idx;
    logic [CW-1:0]           next_ptr;
    logic [N_CLIENTS-1:0]    req_eligible;
    logic [N_CLIENTS-1:0]    arb_grant;
    logic [CW-1:0]           arb_idx;
    logic                    arb_valid;
    logic [BUS_W-1:0]        tx_flit_arr [N_CLIENTS];

    logic [1:0]                  rx_state;
    logic [CW-1:0]               rx_idx;
    logic [CLIENT_FIELD_W-1:0]   nd_sel;
    logic                        nd_sel_ok;

    for (genvar i = 0; i < N_CLIENTS; i++) begin : g_flit_unpack
        assign tx_flit_arr[i] = tx_flit_i[i*BUS_W +: BUS_W];
    end

    // A client whose ack is on the wire this cycle has not yet seen it, so it may still be
    // requesting; masking it prevents a second send of the same flit.
    assign req_eligible = tx_req_i & ~tx_ack_o;
    assign next_ptr     = (tx_idx == CW'(N_CLIENTS - 1)) ? '0 : tx_idx + 1'b1;
    assign noc_wr_o     = (tx_state == T_SEND);

    rtsnoc_rr_arbiter #(
        .N_CLIENTS (N_CLIENTS),
        .CW        (CW)
    ) u_rr_arbiter (
        .req         (req_eligible),
        .ptr         (rr_ptr),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_state  <= T_IDLE;
            rr_ptr    <= '0;
            tx_idx    <= '0;
            noc_din_o <= '0;
            tx_ack_o  <= '0;
        end else begin
            tx_ack_o <= '0;
            if (tx_state == T_IDLE) begin
                if (arb_valid) begin
                    noc_din_o <= tx_flit_arr[arb_idx];
                    tx_idx    <= arb_idx;
                    tx_state  <= T_SEND;
                end
            end else if (!noc_wait_i) begin
                tx_ack_o <= ONE_HOT_0 << tx_idx;
                rr_ptr   <= next_ptr;
                tx_state <= T_IDLE;
            end
        end
    end

    assign nd_sel    = noc_dout_i[NOC_DATA_WIDTH-1 -: CLIENT_FIELD_W];
    assign nd_sel_ok = (int'(nd_sel) < N_CLIENTS);

    // R_GAP and the R_OFFER exit both give the router one cycle to refresh noc_nd_i after a pop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_state      <= R_IDLE;
            rx_idx        <= '0;
            rx_flit_o     <= '0;
            rx_valid_o    <= '0;
            rx_drop_cnt_o <= '0;
            noc_rd_o      <= 1'b0;
        end else begin
            noc_rd_o <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    if (noc_nd_i) begin
                        rx_flit_o <= noc_dout_i;
                        noc_rd_o  <= 1'b1;
                        if (nd_sel_ok) begin
                            rx_idx     <= nd_sel[CW-1:0];
                            rx_valid_o <= ONE_HOT_0 << nd_sel[CW-1:0];
                            rx_state   <= R_OFFER;
                        end else begin
                            if (rx_drop_cnt_o != 8'hFF) begin
                                rx_drop_cnt_o <= rx_drop_cnt_o + 8'd1;
                            end
                            rx_state <= R_GAP;
                        end
                    end
                end
                R_OFFER: begin
                    if (rx_ready_i[rx_idx]) begin
                        rx_valid_o <= '0;
                        rx_state   <= R_IDLE;
                    end
                end
                R_GAP:   rx_state <= R_IDLE;
                default: rx_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtsnoc_port_arbiter.sv
// Directed plus randomized bench for rtsnoc_port_arbiter against a transaction-level model.
module tb_rtsnoc_port_arbiter;

    localparam int N     = 4;
    localparam int NDW   = 56;
    localparam int SX    = 1;
    localparam int SY    = 1;
    localparam int BUS_W = NDW + 6 + 2 * SX + 2 * SY;

    logic                 clk_i;
    logic                 rst_n_i;
    logic [N-1:0]         tx_req_i;
    logic [N*BUS_W-1:0]   tx_flit_i;
    logic [N-1:0]         tx_ack_o;
    logic [N-1:0]         rx_valid_o;
    logic [N-1:0]         rx_ready_i;
    logic [BUS_W-1:0]     rx_flit_o;
    logic [7:0]           rx_drop_cnt_o;
    logic [BUS_W-1:0]     noc_din_o;
    logic                 noc_wr_o;
    logic                 noc_wait_i;
    logic [BUS_W-1:0]     noc_dout_i;
    logic                 noc_nd_i;
    logic                 noc_rd_o;

    logic [BUS_W-1:0]     client_flit [N];
    int                   test_count;
    int                   fail_count;
    int                   exp_ptr;
    int                   exp_drops;

    for (genvar i = 0; i < N; i++) begin : g_flit_pack
        assign tx_flit_i[i*BUS_W +: BUS_W] = client_flit[i];
    end

    rtsnoc_port_arbiter #(
        .N_CLIENTS      (N),
        .NOC_DATA_WIDTH (NDW),
        .SOC_SIZE_X     (SX),
        .SOC_SIZE_Y     (SY)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .tx_req_i      (tx_req_i),
        .tx_flit_i     (tx_flit_i),
        .tx_ack_o      (tx_ack_o),
        .rx_valid_o    (rx_valid_o),
        .rx_ready_i    (rx_ready_i),
        .rx_flit_o     (rx_flit_o),
        .rx_drop_cnt_o (rx_drop_cnt_o),
        .noc_din_o     (noc_din_o),
        .noc_wr_o      (noc_wr_o),
        .noc_wait_i    (noc_wait_i),
        .noc_dout_i    (noc_dout_i),
        .noc_nd_i      (noc_nd_i),
        .noc_rd_o      (noc_rd_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [BUS_W-1:0] randFlit();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[BUS_W-1:0];
    endfunction

    // Round-robin rule: first requester at or after the pointer, wrapping around.
    function automatic int pickRr(input logic [N-1:0] mask, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (mask[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        test_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // New requesters present a fresh flit; clients already requesting keep theirs stable.
    task automatic applyStimulus(input logic [N-1:0] add_req);
        for (int i = 0; i < N; i++) begin
            if (add_req[i] && !tx_req_i[i]) client_flit[i] = randFlit();
        end
        tx_req_i = tx_req_i | add_req;
    endtask

    task automatic runTx(input int wait_cycles);
        int g;
        logic [BUS_W-1:0] f;
        g = pickRr(tx_req_i, exp_ptr);
        if (g < 0) return;
        f = client_flit[g];
        noc_wait_i = (wait_cycles > 0);
        for (int c = 1; c <= wait_cycles + 1; c++) begin
            tick();
            checkOutput("tx_wr", noc_wr_o, 1);
            checkOutput("tx_din", noc_din_o, f);
            checkOutput("tx_ack_early", tx_ack_o, 0);
            if (c == 1 && $urandom_range(0, 3) == 0) begin
                tx_req_i[g]    = 1'b0;
                client_flit[g] = randFlit();
            end
            if (c == wait_cycles + 1) noc_wait_i = 1'b0;
        end
        tick();
        checkOutput("tx_ack", tx_ack_o, N'(1) << g);
        checkOutput("tx_wr_low", noc_wr_o, 0);
        tx_req_i[g] = 1'b0;
        exp_ptr = (g + 1) % N;
    endtask

    task automatic rxFlit(input int sel, input int delay);
        logic [BUS_W-1:0] f;
        f = randFlit();
        f[NDW-1 -: 3] = 3'(sel);
        noc_dout_i = f;
        noc_nd_i   = 1'b1;
        tick();
        checkOutput("rx_rd", noc_rd_o, 1);
        checkOutput("rx_flit", rx_flit_o, f);
        if (sel < N) begin
            checkOutput("rx_valid", rx_valid_o, N'(1) << sel);
            checkOutput("rx_drops_hold", rx_drop_cnt_o, exp_drops);
            noc_dout_i = randFlit();
            for (int d = 0; d < delay; d++) begin
                rx_ready_i = N'($urandom()) & ~(N'(1) << sel);
                tick();
                checkOutput("rx_no_pop", noc_rd_o, 0);
                checkOutput("rx_valid_hold", rx_valid_o, N'(1) << sel);
                checkOutput("rx_flit_hold", rx_flit_o, f);
            end
            rx_ready_i = N'($urandom()) | (N'(1) << sel);
            tick();
            checkOutput("rx_valid_clear", rx_valid_o, 0);
            checkOutput("rx_rd_after", noc_rd_o, 0);
            rx_ready_i = '0;
            noc_nd_i   = 1'b0;
        end else begin
            exp_drops = (exp_drops < 255) ? exp_drops + 1 : 255;
            checkOutput("rx_drop_novalid", rx_valid_o, 0);
            checkOutput("rx_drops", rx_drop_cnt_o, exp_drops);
            tick();
            checkOutput("rx_gap_rd", noc_rd_o, 0);
            checkOutput("rx_gap_valid", rx_valid_o, 0);
        end
    endtask

    initial begin
        int g;
        logic [N-1:0] add;
        logic [BUS_W-1:0] f;
        test_count = 0;
        fail_count = 0;
        exp_ptr    = 0;
        exp_drops  = 0;
        rst_n_i    = 1'b0;
        tx_req_i   = '0;
        rx_ready_i = '0;
        noc_wait_i = 1'b0;
        noc_dout_i = '0;
        noc_nd_i   = 1'b0;
        for (int i = 0; i < N; i++) client_flit[i] = '0;

        tick();
        tick();
        checkOutput("rst_ctrl", {noc_wr_o, noc_rd_o, tx_ack_o, rx_valid_o, rx_drop_cnt_o}, 0);
        checkOutput("rst_din", noc_din_o, 0);
        checkOutput("rst_rxflit", rx_flit_o, 0);
        rst_n_i = 1'b1;
        tick();

        // All clients request continuously with no back-pressure.
        applyStimulus('1);
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c % 2 == 1) begin
                g = pickRr('1, exp_ptr);
                checkOutput("t2_wr", noc_wr_o, 1);
                checkOutput("t2_din", noc_din_o, client_flit[g]);
                checkOutput("t2_ack_odd", tx_ack_o, 0);
            end else begin
                checkOutput("t2_ack", tx_ack_o, N'(1) << g);
                checkOutput("t2_wr_even", noc_wr_o, 0);
                client_flit[g] = randFlit();
                exp_ptr = (g + 1) % N;
            end
        end
        tx_req_i = '0;
        tick();

        // Single client 2, then clients 0 and 3 together exercise the moved pointer.
        applyStimulus(4'b0100);
        runTx(0);
        applyStimulus(4'b1001);
        runTx(0);
        runTx(0);
        tx_req_i = '0;

        // Back-pressure held for five cycles on client 1.
        applyStimulus(4'b0010);
        runTx(5);
        tick();
        checkOutput("t3_single_ack", tx_ack_o, 0);

        repeat (40) begin
            add = N'($urandom());
            if ((tx_req_i | add) == '0) add[$urandom_range(0, N - 1)] = 1'b1;
            applyStimulus(add);
            runTx($urandom_range(0, 3));
        end
        tx_req_i = '0;
        tick();

        rxFlit(3, 4);
        repeat (30) rxFlit($urandom_range(0, 7), $urandom_range(0, 3));
        noc_nd_i = 1'b0;
        tick();

        repeat (300) rxFlit(5, 0);
        noc_nd_i = 1'b0;
        tick();
        checkOutput("t5_sat", rx_drop_cnt_o, 255);

        // Reset while TX is in T_SEND and RX is offering to client 2.
        applyStimulus(4'b0010);
        noc_wait_i = 1'b1;
        f = randFlit();
        f[NDW-1 -: 3] = 3'd2;
        noc_dout_i = f;
        noc_nd_i   = 1'b1;
        tick();
        noc_nd_i = 1'b0;
        checkOutput("t6_wr_pre", noc_wr_o, 1);
        checkOutput("t6_valid_pre", rx_valid_o, 4'b0100);
        #3 rst_n_i = 1'b0;
        #1;
        checkOutput("t6_async_ctrl", {noc_wr_o, noc_rd_o, tx_ack_o, rx_valid_o, rx_drop_cnt_o}, 0);
        checkOutput("t6_async_din", noc_din_o, 0);
        checkOutput("t6_async_rxflit", rx_flit_o, 0);
        noc_wait_i = 1'b0;
        tx_req_i   = '0;
        rx_ready_i = '1;
        tick();
        tick();
        rst_n_i    = 1'b1;
        rx_ready_i = '0;
        exp_ptr    = 0;
        exp_drops  = 0;
        tick();
        tick();
        checkOutput("t6_no_ack", {tx_ack_o, rx_valid_o, noc_wr_o}, 0);
        applyStimulus('1);
        runTx(0);
        tx_req_i = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
